// File: rtl/trace_event_player.sv
// trace_event_player: replays a table of timestamped events onto
// per-stream value/new_input pulses feeding a monitor.
module trace_event_player #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_W      = 64,
    parameter int DELTA_W     = 32,
    parameter int ADDR_W      = 4,
    parameter int LOOP        = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DELTA_W-1:0]           wr_delta,
    input  logic [NUM_INPUTS-1:0]        wr_mask,
    input  logic [NUM_INPUTS*DATA_W-1:0] wr_data,
    output logic                         wr_err,
    input  logic [ADDR_W:0]              num_events,
    input  logic                         start,
    input  logic                         abort,
    output logic [NUM_INPUTS*DATA_W-1:0] inputs,
    output logic [NUM_INPUTS-1:0]        new_inputs,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_W-1:0]            event_idx,
    input  logic [NUM_OUTPUTS-1:0]       aktv_in,
    output logic [15:0]                  aktv_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_V = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FIRE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [DELTA_W-1:0]           delta_mem [DEPTH];
    logic [NUM_INPUTS-1:0]        mask_mem  [DEPTH];
    logic [NUM_INPUTS*DATA_W-1:0] data_mem  [DEPTH];

    logic [ADDR_W-1:0]            idx, idx_n;
    logic [DELTA_W-1:0]           cnt, cnt_n;
    logic [ADDR_W:0]              n_q, n_n, n_clamp;
    logic [NUM_INPUTS*DATA_W-1:0] inputs_n;
    logic [NUM_INPUTS-1:0]        new_n;
    logic [NUM_INPUTS-1:0]        rd_mask;
    logic [NUM_INPUTS*DATA_W-1:0] rd_data;
    logic                         idle_like;
    logic                         start_ok;
    logic                         last;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign start_ok  = idle_like && start && !abort;
    assign busy      = (state == S_WAIT) || (state == S_FIRE);
    assign done      = (state == S_DONE);
    assign event_idx = idx;
    assign n_clamp   = (num_events > DEPTH_V) ? DEPTH_V : num_events;
    assign last      = ({1'b0, idx} == (n_q - ONE_V));
    assign rd_mask   = mask_mem[idx];
    assign rd_data   = data_mem[idx];

    // Table only changes while no replay is reading it.
    always_ff @(posedge clk) begin
        if (en && wr_en && idle_like) begin
            delta_mem[wr_addr] <= wr_delta;
            mask_mem[wr_addr]  <= wr_mask;
            data_mem[wr_addr]  <= wr_data;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        n_n      = n_q;
        inputs_n = '0;
        new_n    = '0;
        if (abort) begin
            state_n = S_IDLE;
            idx_n   = '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_n = n_clamp;
                        if (n_clamp == '0) begin
                            state_n = S_DONE;
                        end else begin
                            state_n = S_WAIT;
                            idx_n   = '0;
                            cnt_n   = delta_mem[0];
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state_n = S_FIRE;
                        new_n   = rd_mask;
                        for (int k = 0; k < NUM_INPUTS; k++) begin
                            if (rd_mask[k])
                                inputs_n[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W];
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_FIRE: begin
                    if (last) begin
                        if (LOOP != 0) begin
                            state_n = S_WAIT;
                            idx_n   = '0;
                            cnt_n   = delta_mem[0];
                        end else begin
                            state_n = S_DONE;
                        end
                    end else begin
                        state_n = S_WAIT;
                        idx_n   = idx + 1'b1;
                        cnt_n   = delta_mem[idx + 1'b1];
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            n_q        <= '0;
            inputs     <= '0;
            new_inputs <= '0;
            wr_err     <= 1'b0;
            aktv_count <= '0;
        end else if (en) begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            n_q        <= n_n;
            inputs     <= inputs_n;
            new_inputs <= new_n;
            wr_err     <= wr_en && busy;
            if (start_ok)
                aktv_count <= '0;
            else if (|aktv_in && aktv_count != 16'hFFFF)
                aktv_count <= aktv_count + 16'd1;
        end
    end

endmodule

// File: doc/trace_event_player.md
Name: trace_event_player

Overview:
Synthesizable, parametrised replacement for hand-written monitor stimulus sequences.
- Stores a table of timestamped input events and replays them onto the monitor's per-stream value/new_input pairs. Each event is a one-cycle pulse; values return to zero afterwards.
- Generalises channel count, data width and trace depth, and adds loop mode, abort, enable stall and an output-activity counter.
- Sits between the bench/host load path and the monitor's input ports.

Parameters:
NUM_INPUTS, 2, number of input streams driven
NUM_OUTPUTS, 4, number of monitor output activity flags observed
DATA_W, 64, width of each input value (signed, passed through unmodified)
DELTA_W, 32, width of the inter-event gap field
ADDR_W, 4, trace table address width; DEPTH = 2**ADDR_W
LOOP, 0, 1 = restart at entry 0 after the last event instead of stopping

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable; low freezes all state, counters and outputs
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  entry index
wr_delta  in  DELTA_W  gap before this event
wr_mask  in  NUM_INPUTS  per-stream new flag for this event
wr_data  in  NUM_INPUTS*DATA_W  flattened values, stream 0 in LSBs
wr_err  out  1  one-cycle pulse: write dropped because busy
num_events  in  ADDR_W+1  trace length, clamped to DEPTH
start  in  1  begin replay (accepted in IDLE/DONE only)
abort  in  1  stop replay
inputs  out  NUM_INPUTS*DATA_W  flattened stream values to monitor
new_inputs  out  NUM_INPUTS  per-stream new_input pulses
busy  out  1  state is WAIT or FIRE
done  out  1  state is DONE
event_idx  out  ADDR_W  current table entry
aktv_in  in  NUM_OUTPUTS  monitor output activity flags
aktv_count  out  16  cycles with any aktv_in bit set, saturating

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: state=IDLE; inputs=0, new_inputs=0, busy=0, done=0, event_idx=0, wr_err=0, aktv_count=0. Table contents are not reset.
- All updates happen only when en=1. With en=0, everything holds, including an active FIRE pulse, and writes are ignored.
- States:
  - IDLE: wait for start.
  - WAIT: countdown to the next event.
  - FIRE: one-cycle event presentation.
  - DONE: trace complete.
- IDLE/DONE + start:
  - If clamped num_events=0: go to DONE.
  - Otherwise: next cycle WAIT, idx=0, cnt=delta[0], aktv_count cleared.
- WAIT:
  - If cnt=0: next cycle FIRE, with new_inputs=mask[idx]. inputs slice k = data[idx][k] if mask bit k is set, else 0.
  - Otherwise cnt decrements.
- FIRE lasts exactly one cycle. Next cycle inputs and new_inputs are 0.
  - If idx = num_events-1: LOOP=1 goes to WAIT with idx=0, cnt=delta[0]; LOOP=0 goes to DONE.
  - Otherwise: WAIT with idx+1, cnt=delta[idx+1].
- Timing:
  - Start accepted at cycle s gives the first FIRE at s+2+delta[0].
  - Consecutive FIREs are delta+2 cycles apart. delta=0 gives the minimum spacing of 2.
- abort (any state, priority over start): next cycle IDLE, outputs zeroed, idx=0. An abort during FIRE truncates nothing: the pulse is already presented.
- Simultaneous rst and any input: rst wins.
- Table writes:
  - Accepted in IDLE/DONE; a write takes effect for reads starting the next cycle.
  - In WAIT/FIRE a write is dropped and wr_err pulses in the following cycle.
- aktv_count increments once per enabled cycle in which |aktv_in=1, in any state. It saturates at 0xFFFF and is cleared only by rst or an accepted start.
- Table read path: combinational or registered, but the FIRE timing above is mandatory.

Test Plan:
- Two entries (d=10, mask=11, data=1/1; d=5, mask=01, data=2/9), start at cycle s -> FIRE at s+12 with inputs 1/1, new=11; FIRE at s+19 with inputs 2/0, new=01; done=1 at s+20; all outputs 0 between pulses.
- Three entries with delta=0, LOOP=0 -> FIREs at s+2, s+4, s+6; no two consecutive cycles with new_inputs set.
- num_events=0 -> DONE one cycle after start, no pulses. num_events=31 with ADDR_W=4 -> exactly 16 FIREs.
- abort at the 5th WAIT cycle -> IDLE next cycle, no FIRE; a subsequent start replays from entry 0 with the original timing.
- wr_en during WAIT -> wr_err pulse, table unchanged (replayed data matches the original). Hold en=0 for 7 cycles mid-WAIT -> FIRE delayed by exactly 7.
- LOOP=1 with 2 entries, aktv_in tied to new_inputs[0] -> periodic FIREs. aktv_count equals the number of fires of stream 0, and saturates at 65535 in a long run.
